dmem_responder: RTL and testbench

- Data-memory responder: the memory-side end of the core's load/store request interface.
- Accepts one load or store request at a time over a valid/ready handshake and decodes RV32I load/store funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW).
- Performs byte-lane selection, sign/zero extension and range/alignment checking.
- Returns a response after a fixed, parameterised latency over a second valid/ready handshake.
- Sits between the core's memory stage and the on-chip word-organised data RAM, which is an internal array in this block.

---
 rtl/dmem_responder.sv | 148 ++++++++++++++
 tb/tb_dmem_responder.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Memory-side responder for RV32I load/store requests: decodes funct3, checks range and
// alignment, accesses the internal word array and answers after LATENCY cycles.
module dmem_responder #(
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t             state, state_nxt;
   logic [3:0]         cnt, cnt_nxt;
   logic [31:0]        mem [DEPTH_WORDS];
   logic               accept;
   logic               f3_bad, misalign, out_of_range, err_now;
   logic [IDX_W-1:0]   idx;
   logic [3:0]         be;
   logic [31:0]        wdata_lane;
   logic [31:0]        word_p1;
   logic               we_p1, err_p1;
   logic [2:0]         f3_p1;
   logic [1:0]         lane_p1;

   function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [2:0] f3,
                                                input logic [1:0] lane);
      logic [7:0]  b;
      logic [15:0] h;
      case (lane)
         2'd0:    b = word[7:0];
         2'd1:    b = word[15:8];
         2'd2:    b = word[23:16];
         default: b = word[31:24];
      endcase
      h = lane[1] ? word[31:16] : word[15:0];
      case (f3)
         3'b000:  return {{24{b[7]}}, b};
         3'b100:  return {24'h0, b};
         3'b001:  return {{16{h[15]}}, h};
         3'b101:  return {16'h0, h};
         default: return word;
      endcase
   endfunction

   assign req_ready = (state == IDLE) && !rst;
   assign rsp_valid = (state == RESP);
   assign rsp_err   = err_p1;
   assign rsp_rdata = (rsp_valid && !err_p1 && !we_p1) ? load_extend(word_p1, f3_p1, lane_p1) : 32'h0;
   assign accept    = req_valid && req_ready;
   assign idx       = req_addr[IDX_W+1:2];

   always_comb begin
      f3_bad = 1'b1;
      if (req_we) begin
         f3_bad = req_funct3[2] || (req_funct3[1:0] == 2'b11);
      end else begin
         case (req_funct3)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: f3_bad = 1'b0;
            default:                                 f3_bad = 1'b1;
         endcase
      end
   end

   assign misalign     = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                         ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
   assign out_of_range = req_addr[31:2] >= 30'(DEPTH_WORDS);
   assign err_now      = f3_bad || misalign || out_of_range;

   // Byte enables and lane-replicated store data
   always_comb begin
      be         = 4'b1111;
      wdata_lane = req_wdata;
      case (req_funct3[1:0])
         2'b00: begin
            be         = 4'b0001 << req_addr[1:0];
            wdata_lane = {4{req_wdata[7:0]}};
         end
         2'b01: begin
            be         = req_addr[1] ? 4'b1100 : 4'b0011;
            wdata_lane = {2{req_wdata[15:0]}};
         end
         default: ;
      endcase
   end

   // Acceptance edge: read old word, commit legal store, capture decode for the response
   always_ff @(posedge clk) begin
      if (accept) begin
         word_p1 <= mem[idx];
         we_p1   <= req_we;
         f3_p1   <= req_funct3;
         lane_p1 <= req_addr[1:0];
         if (req_we && !err_now) begin
            for (int b = 0; b < 4; b++) begin
               if (be[b]) mem[idx][8*b +: 8] <= wdata_lane[8*b +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         cnt    <= 4'd0;
         err_p1 <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (accept) err_p1 <= err_now;
      end
   end

   // Counter holds the remaining wait cycles; RESP is entered as it reaches zero
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            if (accept) begin
               cnt_nxt   = 4'(LATENCY - 1);
               state_nxt = (LATENCY == 1) ? RESP : WAIT;
            end
         end
         WAIT: begin
            cnt_nxt = cnt - 4'd1;
            if (cnt == 4'd1) state_nxt = RESP;
         end
         RESP: begin
            if (rsp_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: one instance with LATENCY=1, one with LATENCY=4.
module tb_dmem_responder;

   logic              clk = 1'b0;
   logic              rst;
   logic [1:0]        req_valid, req_we, rsp_ready, req_ready, rsp_valid, rsp_err;
   logic [1:0][2:0]   req_funct3;
   logic [1:0][31:0]  req_addr, req_wdata, rsp_rdata;

   typedef struct packed {
      logic        err;
      logic [31:0] rdata;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] shadow [8];
   int          n_tests = 0;
   int          n_fail  = 0;

   always #5 clk = ~clk;

   dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(1)) u_dut0 (
      .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
      .req_we(req_we[0]), .req_funct3(req_funct3[0]), .req_addr(req_addr[0]),
      .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
      .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
   );

   dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(4)) u_dut1 (
      .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
      .req_we(req_we[1]), .req_funct3(req_funct3[1]), .req_addr(req_addr[1]),
      .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
      .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic int lat_of(input int d);
      return (d == 0) ? 1 : 4;
   endfunction

   // Reference behaviour on the shadow window (byte addresses 0x100..0x11F)
   task automatic model_op(input logic we, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, output logic [31:0] rd, output logic err);
      int          wi, sh;
      logic [31:0] w, t;
      err = (we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 > 3'd5)) ||
            (f3[1:0] == 2'b01 && a[0]) || (f3 == 3'd2 && a[1:0] != 2'b00) ||
            (a[31:2] >= 30'd1024);
      rd = 32'h0;
      if (err) return;
      wi = int'(a[31:2]) - 64;
      sh = 8 * int'(a[1:0]);
      w  = shadow[wi];
      t  = w >> sh;
      if (we) begin
         case (f3)
            3'd0:    shadow[wi][sh +: 8]  = wd[7:0];
            3'd1:    shadow[wi][sh +: 16] = wd[15:0];
            default: shadow[wi] = wd;
         endcase
      end else begin
         case (f3)
            3'd0:    rd = {{24{t[7]}}, t[7:0]};
            3'd4:    rd = {24'h0, t[7:0]};
            3'd1:    rd = {{16{t[15]}}, t[15:0]};
            3'd5:    rd = {16'h0, t[15:0]};
            default: rd = w;
         endcase
      end
   endtask

   task automatic xact(input int d, input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err,
                       input int hold, input bit keep);
      int          n;
      exp_t        e;
      logic [31:0] rd0;
      @(negedge clk);
      chk("req_ready_idle", 32'(req_ready[d]), 32'd1);
      req_valid[d] = 1'b1; req_we[d] = we; req_funct3[d] = f3;
      req_addr[d] = a; req_wdata[d] = wd;
      exp_q.push_back('{err: exp_err, rdata: exp_rd});
      n = 0;
      while (!req_ready[d] && n < 20) begin @(negedge clk); n++; end
      @(posedge clk); #1;
      if (keep) begin
         req_we[d] = 1'b1; req_funct3[d] = 3'b010; req_addr[d] = 32'h30; req_wdata[d] = 32'hBADBAD00;
      end else begin
         req_valid[d] = 1'b0; req_we[d] = ~we; req_funct3[d] = 3'($urandom);
         req_addr[d] = $urandom; req_wdata[d] = $urandom;
      end
      n = 0;
      do begin
         @(negedge clk); n++;
         if (!rsp_valid[d]) chk("req_ready_busy", 32'(req_ready[d]), 32'd0);
      end while (!rsp_valid[d] && n < 40);
      chk("latency", 32'(n), 32'(lat_of(d)));
      if (!rsp_valid[d]) begin
         void'(exp_q.pop_front());
         req_valid[d] = 1'b0;
         return;
      end
      rd0 = rsp_rdata[d];
      repeat (hold) begin
         @(negedge clk);
         chk("hold_valid", 32'(rsp_valid[d]), 32'd1);
         chk("hold_rdata", rsp_rdata[d], rd0);
         chk("hold_req_ready", 32'(req_ready[d]), 32'd0);
      end
      e = exp_q.pop_front();
      chk("rsp_rdata", rsp_rdata[d], e.rdata);
      chk("rsp_err", 32'(rsp_err[d]), 32'(e.err));
      rsp_ready[d] = 1'b1;
      @(posedge clk); #1;
      rsp_ready[d] = 1'b0;
      chk("valid_drop", 32'(rsp_valid[d]), 32'd0);
      chk("ready_back", 32'(req_ready[d]), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd, a, wd;
      logic        er, we;
      logic [2:0]  f3;
      rst = 1'b1;
      req_valid = '0; req_we = '0; rsp_ready = '0;
      req_funct3 = '0; req_addr = '0; req_wdata = '0;
      repeat (3) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         chk("rst_rsp_valid", 32'(rsp_valid[d]), 32'd0);
         chk("rst_rsp_err", 32'(rsp_err[d]), 32'd0);
         chk("rst_rsp_rdata", rsp_rdata[d], 32'd0);
         chk("rst_req_ready", 32'(req_ready[d]), 32'd0);
      end
      rst = 1'b0;

      // LATENCY=1 instance: directed cases
      xact(0, 1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0,        0, 0, 0);
      xact(0, 0, 3'b010, 32'h10, 32'h0,        32'hDEADBEEF, 0, 0, 0);
      xact(0, 0, 3'b000, 32'h13, 32'h0,        32'hFFFFFFDE, 0, 0, 0);
      xact(0, 0, 3'b100, 32'h13, 32'h0,        32'h000000DE, 0, 0, 0);
      xact(0, 0, 3'b001, 32'h12, 32'h0,        32'hFFFFDEAD, 0, 1, 0);
      xact(0, 0, 3'b101, 32'h10, 32'h0,        32'h0000BEEF, 0, 0, 0);
      xact(0, 1, 3'b000, 32'h11, 32'h000000AA, 32'h0,        0, 0, 0);
      xact(0, 1, 3'b001, 32'h12, 32'h00001234, 32'h0,        0, 0, 0);
      xact(0, 0, 3'b010, 32'h10, 32'h0,        32'h1234AAEF, 0, 0, 0);
      xact(0, 0, 3'b010, 32'h11, 32'h0,        32'h0,        1, 0, 0);
      xact(0, 1, 3'b010, 32'h14, 32'h11223344, 32'h0,        0, 0, 0);
      xact(0, 1, 3'b001, 32'h15, 32'h0000FFFF, 32'h0,        1, 0, 0);
      xact(0, 0, 3'b010, 32'h14, 32'h0,        32'h11223344, 0, 0, 0);
      xact(0, 0, 3'b011, 32'h10, 32'h0,        32'h0,        1, 0, 0);
      xact(0, 1, 3'b100, 32'h14, 32'hFFFFFFFF, 32'h0,        1, 0, 0);
      xact(0, 0, 3'b010, 32'h14, 32'h0,        32'h11223344, 0, 0, 0);
      xact(0, 0, 3'b010, 32'h1000, 32'h0,      32'h0,        1, 0, 0);
      xact(0, 1, 3'b010, 32'hFFC, 32'hCAFEF00D, 32'h0,       0, 0, 0);
      xact(0, 0, 3'b010, 32'hFFC, 32'h0,       32'hCAFEF00D, 0, 0, 0);

      // LATENCY=4 instance: stalls and back-to-back acceptance
      xact(1, 1, 3'b010, 32'h30, 32'h600D600D, 32'h0,        0, 0, 0);
      xact(1, 1, 3'b010, 32'h40, 32'h80017F80, 32'h0,        0, 0, 0);
      xact(1, 0, 3'b010, 32'h40, 32'h0,        32'h80017F80, 0, 3, 0);
      xact(1, 0, 3'b001, 32'h42, 32'h0,        32'hFFFF8001, 0, 0, 0);
      xact(1, 0, 3'b000, 32'h40, 32'h0,        32'hFFFFFF80, 0, 2, 0);
      xact(1, 0, 3'b010, 32'h40, 32'h0,        32'h80017F80, 0, 1, 1);
      xact(1, 0, 3'b010, 32'h30, 32'h0,        32'h600D600D, 0, 0, 0);

      // Reset while the store response is still pending
      @(negedge clk);
      req_valid[1] = 1'b1; req_we[1] = 1'b1; req_funct3[1] = 3'b010;
      req_addr[1] = 32'h20; req_wdata[1] = 32'h55;
      @(posedge clk); #1;
      req_valid[1] = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1 chk("rst_mid_req_ready", 32'(req_ready[1]), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1 chk("rst_mid_ready_after", 32'(req_ready[1]), 32'd1);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("rst_mid_no_rsp", 32'(rsp_valid[1]), 32'd0);
      end
      xact(1, 0, 3'b010, 32'h20, 32'h0, 32'h00000055, 0, 0, 0);

      // Randomised traffic against the shadow model
      for (int i = 0; i < 8; i++) begin
         wd = $urandom;
         model_op(1'b1, 3'b010, 32'h100 + 32'(4 * i), wd, rd, er);
         xact(0, 1, 3'b010, 32'h100 + 32'(4 * i), wd, rd, er, 0, 0);
      end
      for (int i = 0; i < 40; i++) begin
         we = 1'($urandom_range(0, 1));
         f3 = 3'($urandom_range(0, 7));
         a  = ($urandom_range(0, 7) == 0) ? 32'h1000 + 32'($urandom_range(0, 31))
                                          : 32'h100 + 32'($urandom_range(0, 31));
         wd = $urandom;
         model_op(we, f3, a, wd, rd, er);
         xact(0, we, f3, a, wd, rd, er, $urandom_range(0, 2), 0);
      end

      chk("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
